// File: rtl/century_calendar_clock.sv
// Second-resolution calendar clock with Gregorian leap years, day-of-week and validated load.
// Optional daily alarm enabled by defining CENTURY_ALARM_EN.
module century_calendar_clock #(
    parameter int unsigned YEAR_W     = 13,
    parameter int unsigned START_YEAR = 2000,
    parameter int unsigned END_YEAR   = 2099,
    parameter int unsigned START_WDAY = 6
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              load,
    input  logic [5:0]        ld_sec,
    input  logic [5:0]        ld_min,
    input  logic [4:0]        ld_hour,
    input  logic [4:0]        ld_day,
    input  logic [3:0]        ld_mont,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [2:0]        ld_wday,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        mont,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        wday,
    output logic              load_err,
    output logic              century_wrap
`ifdef CENTURY_ALARM_EN
    ,
    input  logic              alarm_set,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic              alarm_hit
`endif
);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                 input logic [YEAR_W-1:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    logic              carry_sec, carry_min, carry_hour, carry_day, carry_mont, wrap;
    logic [5:0]        sec_t, min_t;
    logic [4:0]        hour_t, day_t;
    logic [3:0]        mont_t;
    logic [YEAR_W-1:0] year_t;
    logic [2:0]        wday_t;
    logic              ld_valid;

    always_comb begin
        carry_sec  = (sec == 6'd59);
        carry_min  = carry_sec && (min == 6'd59);
        carry_hour = carry_min && (hour == 5'd23);
        carry_day  = carry_hour && (day == days_in_month(mont, year));
        carry_mont = carry_day && (mont == 4'd12);
        wrap       = carry_mont && (year == YEAR_W'(END_YEAR));

        sec_t  = carry_sec ? 6'd0 : sec + 6'd1;
        min_t  = carry_min ? 6'd0 : (carry_sec ? min + 6'd1 : min);
        hour_t = carry_hour ? 5'd0 : (carry_min ? hour + 5'd1 : hour);
        day_t  = carry_day ? 5'd1 : (carry_hour ? day + 5'd1 : day);
        mont_t = carry_mont ? 4'd1 : (carry_day ? mont + 4'd1 : mont);
        year_t = wrap ? YEAR_W'(START_YEAR) : (carry_mont ? year + YEAR_W'(1) : year);
        wday_t = carry_hour ? ((wday == 3'd6) ? 3'd0 : wday + 3'd1) : wday;

        ld_valid = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (ld_hour <= 5'd23) &&
                   (ld_mont >= 4'd1) && (ld_mont <= 4'd12) &&
                   (ld_year >= YEAR_W'(START_YEAR)) && (ld_year <= YEAR_W'(END_YEAR)) &&
                   (ld_day >= 5'd1) && (ld_day <= days_in_month(ld_mont, ld_year)) &&
                   (ld_wday <= 3'd6);
    end

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            sec          <= '0;
            min          <= '0;
            hour         <= '0;
            day          <= 5'd1;
            mont         <= 4'd1;
            year         <= YEAR_W'(START_YEAR);
            wday         <= 3'(START_WDAY);
            load_err     <= 1'b0;
            century_wrap <= 1'b0;
        end else begin
            load_err     <= 1'b0;
            century_wrap <= 1'b0;
            // A load, accepted or rejected, always swallows a coincident tick.
            if (load) begin
                if (ld_valid) begin
                    sec  <= ld_sec;
                    min  <= ld_min;
                    hour <= ld_hour;
                    day  <= ld_day;
                    mont <= ld_mont;
                    year <= ld_year;
                    wday <= ld_wday;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_en) begin
                sec          <= sec_t;
                min          <= min_t;
                hour         <= hour_t;
                day          <= day_t;
                mont         <= mont_t;
                year         <= year_t;
                wday         <= wday_t;
                century_wrap <= wrap;
            end
        end
    end

`ifdef CENTURY_ALARM_EN
    logic       alarm_armed;
    logic [4:0] alarm_hour_r;
    logic [5:0] alarm_min_r;

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            alarm_armed  <= 1'b0;
            alarm_hour_r <= '0;
            alarm_min_r  <= '0;
            alarm_hit    <= 1'b0;
        end else begin
            alarm_hit <= alarm_armed && tick_en && !load && carry_sec &&
                         (min_t == alarm_min_r) && (hour_t == alarm_hour_r);
            if (alarm_set) begin
                if ((alarm_hour <= 5'd23) && (alarm_min <= 6'd59)) begin
                    alarm_hour_r <= alarm_hour;
                    alarm_min_r  <= alarm_min;
                    alarm_armed  <= 1'b1;
                end else begin
                    alarm_armed <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_century_calendar_clock.sv
// Directed bench for century_calendar_clock: two instances, 2000-2099 and 2100-2199 ranges.
module tb_century_calendar_clock;

    logic        clk = 1'b0;
    logic        rst, tick_en, load, load2;
    logic [5:0]  ld_sec, ld_min;
    logic [4:0]  ld_hour, ld_day;
    logic [3:0]  ld_mont;
    logic [12:0] ld_year;
    logic [2:0]  ld_wday;

    logic [5:0]  sec1, min1, sec2, min2;
    logic [4:0]  hour1, day1, hour2, day2;
    logic [3:0]  mont1, mont2;
    logic [12:0] year1, year2;
    logic [2:0]  wday1, wday2;
    logic        lerr1, cw1, lerr2, cw2;

    int checks = 0;
    int errors = 0;

`ifdef CENTURY_ALARM_EN
    logic       alarm_set;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       hit1, hit2;
`endif

    always #5 clk = ~clk;

    century_calendar_clock #(
        .YEAR_W(13), .START_YEAR(2000), .END_YEAR(2099), .START_WDAY(6)
    ) dut1 (
        .clk_1Hz(clk), .rst(rst), .tick_en(tick_en), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
        .ld_mont(ld_mont), .ld_year(ld_year), .ld_wday(ld_wday),
        .sec(sec1), .min(min1), .hour(hour1), .day(day1), .mont(mont1), .year(year1),
        .wday(wday1), .load_err(lerr1), .century_wrap(cw1)
`ifdef CENTURY_ALARM_EN
        , .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_hit(hit1)
`endif
    );

    century_calendar_clock #(
        .YEAR_W(13), .START_YEAR(2100), .END_YEAR(2199), .START_WDAY(5)
    ) dut2 (
        .clk_1Hz(clk), .rst(rst), .tick_en(tick_en), .load(load2),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
        .ld_mont(ld_mont), .ld_year(ld_year), .ld_wday(ld_wday),
        .sec(sec2), .min(min2), .hour(hour2), .day(day2), .mont(mont2), .year(year2),
        .wday(wday2), .load_err(lerr2), .century_wrap(cw2)
`ifdef CENTURY_ALARM_EN
        , .alarm_set(1'b0), .alarm_hour(5'd0), .alarm_min(6'd0), .alarm_hit(hit2)
`endif
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare one instance's full calendar state against hand-computed values.
    task automatic chk_cal(input string tag, input int unsigned which,
                           input int unsigned ey, input int unsigned emo, input int unsigned ed,
                           input int unsigned eh, input int unsigned emi, input int unsigned es,
                           input int unsigned ew);
        if (which == 1) begin
            chk({tag, ".year"}, 32'(year1), ey);
            chk({tag, ".mont"}, 32'(mont1), emo);
            chk({tag, ".day"},  32'(day1), ed);
            chk({tag, ".hour"}, 32'(hour1), eh);
            chk({tag, ".min"},  32'(min1), emi);
            chk({tag, ".sec"},  32'(sec1), es);
            chk({tag, ".wday"}, 32'(wday1), ew);
        end else begin
            chk({tag, ".year"}, 32'(year2), ey);
            chk({tag, ".mont"}, 32'(mont2), emo);
            chk({tag, ".day"},  32'(day2), ed);
            chk({tag, ".hour"}, 32'(hour2), eh);
            chk({tag, ".min"},  32'(min2), emi);
            chk({tag, ".sec"},  32'(sec2), es);
            chk({tag, ".wday"}, 32'(wday2), ew);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input int unsigned y, input int unsigned mo, input int unsigned d,
                          input int unsigned h, input int unsigned mi, input int unsigned s,
                          input int unsigned w);
        ld_year = 13'(y);
        ld_mont = 4'(mo);
        ld_day  = 5'(d);
        ld_hour = 5'(h);
        ld_min  = 6'(mi);
        ld_sec  = 6'(s);
        ld_wday = 3'(w);
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b1; load = 1'b1; load2 = 1'b1;
        set_ld(2050, 5, 5, 5, 5, 5, 5);
`ifdef CENTURY_ALARM_EN
        alarm_set = 1'b0; alarm_hour = '0; alarm_min = '0;
`endif
        #1;
        // Reset overrides load and tick.
        step();
        step();
        chk_cal("reset1", 1, 2000, 1, 1, 0, 0, 0, 6);
        chk("reset1.load_err", 32'(lerr1), 0);
        chk("reset1.wrap", 32'(cw1), 0);
        chk_cal("reset2", 2, 2100, 1, 1, 0, 0, 0, 5);

        rst = 1'b0; load = 1'b0; load2 = 1'b0; tick_en = 1'b1;
        step();
        chk("tick1.sec", 32'(sec1), 1);
        step();
        step();
        chk_cal("tick3", 1, 2000, 1, 1, 0, 0, 3, 6);

        // Leap-day carry in 2000.
        tick_en = 1'b0; load = 1'b1;
        set_ld(2000, 2, 28, 23, 59, 59, 1);
        step();
        chk_cal("ld_0228", 1, 2000, 2, 28, 23, 59, 59, 1);
        chk("ld_0228.load_err", 32'(lerr1), 0);
        load = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("to_0229", 1, 2000, 2, 29, 0, 0, 0, 2);
        tick_en = 1'b0; load = 1'b1;
        set_ld(2000, 2, 29, 23, 59, 59, 2);
        step();
        load = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("to_0301", 1, 2000, 3, 1, 0, 0, 0, 3);

        // 30-day month and hour-only carry.
        tick_en = 1'b0; load = 1'b1;
        set_ld(2001, 4, 30, 23, 59, 59, 1);
        step();
        load = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("to_0501", 1, 2001, 5, 1, 0, 0, 0, 2);
        tick_en = 1'b0; load = 1'b1;
        set_ld(2001, 5, 1, 10, 59, 59, 2);
        step();
        load = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("hour_carry", 1, 2001, 5, 1, 11, 0, 0, 2);

        // Non-leap February 2001 rejects day 29.
        tick_en = 1'b0; load = 1'b1;
        set_ld(2001, 2, 29, 0, 0, 0, 4);
        step();
        chk("bad_2001_0229.load_err", 32'(lerr1), 1);
        chk_cal("bad_2001_0229", 1, 2001, 5, 1, 11, 0, 0, 2);

        // Century year 2100 is not leap.
        load = 1'b0; load2 = 1'b1; tick_en = 1'b0;
        set_ld(2100, 2, 28, 23, 59, 59, 0);
        step();
        chk("ld_2100.load_err", 32'(lerr2), 0);
        load2 = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("to_2100_0301", 2, 2100, 3, 1, 0, 0, 0, 1);
        tick_en = 1'b0; load2 = 1'b1;
        set_ld(2100, 2, 29, 12, 0, 0, 3);
        step();
        chk("bad_2100_0229.load_err", 32'(lerr2), 1);
        chk_cal("bad_2100_0229", 2, 2100, 3, 1, 0, 0, 0, 1);
        load2 = 1'b0;
        step();
        chk("bad_2100_0229.pulse", 32'(lerr2), 0);

        // Century wrap.
        load = 1'b1; tick_en = 1'b0;
        set_ld(2099, 12, 31, 23, 59, 59, 4);
        step();
        chk("ld_2099.wrap", 32'(cw1), 0);
        load = 1'b0; tick_en = 1'b1;
        step();
        chk_cal("wrap", 1, 2000, 1, 1, 0, 0, 0, 5);
        chk("wrap.pulse", 32'(cw1), 1);
        tick_en = 1'b0;
        step();
        chk("wrap.pulse_end", 32'(cw1), 0);
        chk("wrap.hold_sec", 32'(sec1), 0);

        // Load beats tick, including a rejected load.
        load = 1'b1; tick_en = 1'b1;
        set_ld(2000, 6, 15, 12, 34, 10, 4);
        step();
        chk_cal("ld_tick", 1, 2000, 6, 15, 12, 34, 10, 4);
        chk("ld_tick.load_err", 32'(lerr1), 0);
        set_ld(2000, 13, 15, 12, 34, 20, 4);
        step();
        chk("bad_mont.load_err", 32'(lerr1), 1);
        chk_cal("bad_mont", 1, 2000, 6, 15, 12, 34, 10, 4);
        set_ld(2000, 6, 15, 24, 0, 0, 4);
        step();
        chk("bad_hour.load_err", 32'(lerr1), 1);
        chk("bad_hour.sec", 32'(sec1), 10);
        load = 1'b0; tick_en = 1'b1;
        step();
        chk("after_bad.load_err", 32'(lerr1), 0);
        chk("after_bad.sec", 32'(sec1), 11);

`ifdef CENTURY_ALARM_EN
        tick_en = 1'b0; alarm_set = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        step();
        alarm_set = 1'b0; load = 1'b1;
        set_ld(2000, 1, 1, 7, 29, 59, 6);
        step();
        chk("alarm.by_load", 32'(hit1), 0);
        load = 1'b0; tick_en = 1'b1;
        step();
        chk("alarm.hit", 32'(hit1), 1);
        chk_cal("alarm.time", 1, 2000, 1, 1, 7, 30, 0, 6);
        step();
        chk("alarm.pulse_end", 32'(hit1), 0);
        rst = 1'b1;
        step();
        rst = 1'b0; load = 1'b1; tick_en = 1'b0;
        set_ld(2000, 1, 1, 7, 29, 59, 6);
        step();
        load = 1'b0; tick_en = 1'b1;
        step();
        chk("alarm.after_rst", 32'(hit1), 0);
        tick_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
